// File: rtl/conv_pool_relu.sv
// conv_pool_relu
//   2x2 max-pool plus optional ReLU on the fp16 conv result stream, followed by
//   a small FIFO of pooled values.
//
//   Every 4 accepted din samples form one pooling group. The pooled maximum is
//   pushed into the FIFO on the edge that accepts the 4th sample. When relu_en
//   is high on that edge, a pooled value whose sign bit is set is replaced by +0.
//   A push that finds the FIFO full, with no pop on the same edge, is dropped
//   and sets the sticky overflow flag.
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   asynchronous reset, active high
//   clear       in   synchronous flush of all state; overrides din_valid/dout_ready
//   relu_en     in   1 = clamp negative pooled values to +0
//   din_valid   in   din holds a conv result this cycle
//   din[15:0]   in   fp16 conv result
//   dout_ready  in   consumer accepts dout this cycle
//   dout_valid  out  FIFO not empty
//   dout[15:0]  out  FIFO head (0 while empty)
//   fifo_full   out  FIFO holds FIFO_DEPTH entries
//   overflow    out  sticky: a pooled value was dropped
//   group_cnt   out  completed 4-sample groups, wraps at 16 bits
//
// Group phase
//   phase | meaning
//   0     | waiting for 1st sample; it loads run_max unconditionally
//   1     | waiting for 2nd sample; replaces run_max if strictly greater
//   2     | waiting for 3rd sample; replaces run_max if strictly greater
//   3     | waiting for 4th sample; pooled value pushed on acceptance

module conv_pool_relu #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        relu_en,
    input  logic        din_valid,
    input  logic [15:0] din,
    input  logic        dout_ready,
    output logic        dout_valid,
    output logic [15:0] dout,
    output logic        fifo_full,
    output logic        overflow,
    output logic [15:0] group_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);

    // fp16 ordering on raw bits: +0 and -0 compare equal, positives rank by
    // magnitude, negatives by inverse magnitude. NaN/Inf are not special.
    function automatic logic fp16_gt(input logic [15:0] a, input logic [15:0] b);
        logic a_zero;
        logic b_zero;
        a_zero = (a[14:0] == 15'd0);
        b_zero = (b[14:0] == 15'd0);
        if (a_zero && b_zero)
            return 1'b0;
        if (a[15] != b[15])
            return b[15];
        if (!a[15])
            return a[14:0] > b[14:0];
        return a[14:0] < b[14:0];
    endfunction

    logic [1:0]    phase;
    logic [15:0]   run_max;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [15:0]   mem [FIFO_DEPTH];

    logic          din_gt;
    logic [15:0]   pooled;
    logic [15:0]   push_data;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          fifo_empty;

    // Extra pointer bit separates full from empty when the indices match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign dout_valid = !fifo_empty;
    // Masked while empty so dout reads 0 after reset/clear without resetting mem.
    assign dout       = fifo_empty ? 16'h0000 : mem[rd_ptr[AW-1:0]];

    // Equality keeps run_max, i.e. the earlier sample wins ties.
    assign din_gt    = fp16_gt(din, run_max);
    assign pooled    = din_gt ? din : run_max;
    assign push_data = (relu_en && pooled[15]) ? 16'h0000 : pooled;

    assign push_req = !clear && din_valid && (phase == 2'd3);
    assign pop      = !clear && dout_valid && dout_ready;
    // A full FIFO still takes the push when the head leaves on the same edge.
    assign push_ok  = push_req && (!fifo_full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase   <= 2'd0;
            run_max <= 16'h0000;
        end else if (clear) begin
            phase   <= 2'd0;
            run_max <= 16'h0000;
        end else if (din_valid) begin
            phase <= phase + 2'd1;
            if (phase == 2'd0 || ((phase != 2'd3) && din_gt))
                run_max <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            group_cnt <= 16'd0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            group_cnt <= 16'd0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_req && !push_ok)
                overflow <= 1'b1;
            if (push_req)
                group_cnt <= group_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: tb/tb_conv_pool_relu.sv
module tb_conv_pool_relu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        relu_en = 1'b0;
    logic        din_valid = 1'b0;
    logic [15:0] din = 16'h0000;
    logic        dout_ready = 1'b0;
    logic        dout_valid;
    logic [15:0] dout;
    logic        fifo_full;
    logic        overflow;
    logic [15:0] group_cnt;

    int n_checks = 0;
    int n_errors = 0;

    conv_pool_relu #(.FIFO_DEPTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .relu_en    (relu_en),
        .din_valid  (din_valid),
        .din        (din),
        .dout_ready (dout_ready),
        .dout_valid (dout_valid),
        .dout       (dout),
        .fifo_full  (fifo_full),
        .overflow   (overflow),
        .group_cnt  (group_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit reached, want end of test");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // All tasks start and end at a falling edge; outputs are sampled there.
    task automatic send(input logic [15:0] v);
        din_valid = 1'b1;
        din       = v;
        @(negedge clk);
        din_valid = 1'b0;
        din       = 16'h0000;
    endtask

    task automatic send_group(input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c, input logic [15:0] d);
        send(a);
        send(b);
        send(c);
        send(d);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic pop_one();
        dout_ready = 1'b1;
        @(negedge clk);
        dout_ready = 1'b0;
    endtask

    // Group k pools to 0x3800+k (positive, larger than the other three).
    task automatic send_k(input int k);
        send_group(16'h3000 + 16'(k), 16'h3800 + 16'(k), 16'hB900, 16'h2000);
    endtask

    task automatic drain(input string tag, input int n, input logic [15:0] first);
        for (int i = 0; i < n; i++) begin
            check(tag, {15'd0, dout_valid, dout}, {15'd0, 1'b1, first + 16'(i)});
            pop_one();
        end
        check({tag, "_empty"}, {31'd0, dout_valid}, 32'd0);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", {31'd0, dout_valid}, 32'd0);
        check("rst_dout", {16'd0, dout}, 32'h0000);
        check("rst_full", {31'd0, fifo_full}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_gcnt", {16'd0, group_cnt}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1, 2, -1, 0.5 -> 2.0 one cycle after the 4th sample
        relu_en = 1'b0;
        send_group(16'h3C00, 16'h4000, 16'hBC00, 16'h3800);
        check("basic_dout", {16'd0, dout}, 32'h4000);
        check("basic_valid", {31'd0, dout_valid}, 32'd1);
        check("basic_gcnt", {16'd0, group_cnt}, 32'd1);
        pop_one();
        check("basic_popped", {31'd0, dout_valid}, 32'd0);

        // all-negative group: max is -0.5
        relu_en = 1'b1;
        send_group(16'hBC00, 16'hC000, 16'hB800, 16'hC200);
        check("neg_relu", {15'd0, dout_valid, dout}, {15'd0, 1'b1, 16'h0000});
        pop_one();
        relu_en = 1'b0;
        send_group(16'hBC00, 16'hC000, 16'hB800, 16'hC200);
        check("neg_norelu", {16'd0, dout}, 32'hB800);
        pop_one();

        // -0 then +0: equal, earlier (-0) kept; relu turns it into +0
        send_group(16'h8000, 16'h0000, 16'hBC00, 16'h8000);
        check("negzero_keep", {16'd0, dout}, 32'h8000);
        pop_one();
        relu_en = 1'b1;
        send_group(16'h8000, 16'h0000, 16'hBC00, 16'h8000);
        check("negzero_relu", {16'd0, dout}, 32'h0000);
        pop_one();
        relu_en = 1'b0;
        // +0 first, -0 later: also equal, +0 kept
        send_group(16'h0000, 16'h8000, 16'hBC00, 16'h8000);
        check("poszero_keep", {16'd0, dout}, 32'h0000);
        pop_one();
        check("gcnt_6", {16'd0, group_cnt}, 32'd6);

        // overflow: 9 groups with no consumer
        do_clear();
        check("clear_gcnt", {16'd0, group_cnt}, 32'd0);
        for (int k = 0; k < 8; k++)
            send_k(k);
        check("ovf_full8", {31'd0, fifo_full}, 32'd1);
        check("ovf_none8", {31'd0, overflow}, 32'd0);
        send_k(8);
        check("ovf_set9", {31'd0, overflow}, 32'd1);
        check("ovf_gcnt9", {16'd0, group_cnt}, 32'd9);
        drain("ovf_drain", 8, 16'h3800);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        do_clear();
        check("clear_ovf", {31'd0, overflow}, 32'd0);

        // full FIFO, push coincides with pop
        for (int k = 0; k < 8; k++)
            send_k(k);
        send(16'h3008);
        send(16'h3808);
        send(16'hB900);
        dout_ready = 1'b1;
        send(16'h2000);
        dout_ready = 1'b0;
        check("fullpop_full", {31'd0, fifo_full}, 32'd1);
        check("fullpop_ovf", {31'd0, overflow}, 32'd0);
        check("fullpop_gcnt", {16'd0, group_cnt}, 32'd9);
        drain("fullpop_drain", 8, 16'h3801);

        // dout_ready while empty changes nothing
        dout_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        dout_ready = 1'b0;
        check("empty_ready", {31'd0, dout_valid}, 32'd0);

        // clear mid-group with a sample on the same cycle
        do_clear();
        send(16'h4000);
        send(16'h4400);
        din_valid = 1'b1;
        din       = 16'h5000;
        clear     = 1'b1;
        @(negedge clk);
        clear     = 1'b0;
        din_valid = 1'b0;
        check("clr_gcnt0", {16'd0, group_cnt}, 32'd0);
        send_group(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
        check("clr_dout", {15'd0, dout_valid, dout}, {15'd0, 1'b1, 16'h3C00});
        check("clr_gcnt1", {16'd0, group_cnt}, 32'd1);
        pop_one();
        check("clr_single", {31'd0, dout_valid}, 32'd0);

        // async reset with 3 entries and a partial group
        for (int k = 0; k < 3; k++)
            send_k(k);
        send(16'h3000);
        send(16'h3800);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, dout_valid}, 32'd0);
        check("arst_dout", {16'd0, dout}, 32'h0000);
        check("arst_gcnt", {16'd0, group_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        // partial group survives idle cycles
        send(16'h3C00);
        send(16'h4000);
        repeat (5) @(negedge clk);
        check("idle_none", {31'd0, dout_valid}, 32'd0);
        send(16'hBC00);
        send(16'h3800);
        check("arst_after", {15'd0, dout_valid, dout}, {15'd0, 1'b1, 16'h4000});
        check("arst_gcnt1", {16'd0, group_cnt}, 32'd1);
        pop_one();
        check("arst_empty", {31'd0, dout_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/conv_pool_relu.md
CONV_POOL_RELU -- requirements
Module: conv_pool_relu

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning number of pooled fp16 entries buffered; power of two, >= 2.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port clear  input  1  synchronous flush of all state.
REQ-005 SHALL have port relu_en  input  1  1 = clamp negative pooled values to +0.
REQ-006 SHALL have port din_valid  input  1  fp16 conv result present on din this cycle; driven by conv_control dout_valid.
REQ-007 SHALL have port din  input  16  fp16 conv result; driven by conv_control result.
REQ-008 SHALL have port dout_ready  input  1  consumer accepts dout this cycle.
REQ-009 SHALL have port dout_valid  output  1  FIFO head valid.
REQ-010 SHALL have port dout  output  16  fp16 pooled value at FIFO head.
REQ-011 SHALL have port fifo_full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-012 SHALL have port overflow  output  1  sticky; a pooled value was dropped.
REQ-013 SHALL have port group_cnt  output  16  number of completed 4-sample groups, wraps 0xFFFF -> 0.

Function
REQ-014 SHALL treat every 4 consecutive accepted din samples (one 2x2 ofmap tile from conv_control) as one pooling group; 2-bit phase counter 0..3, advances only on din_valid.
REQ-015 SHALL hold a running max register; phase 0 loads din unconditionally, phases 1-2 replace it when din is strictly greater.
REQ-016 SHALL, at the edge accepting phase-3 sample, form pooled = max(running max, din) combinationally and push it into the FIFO on that same edge; phase returns to 0.
REQ-017 SHALL order fp16 as: any positive > any negative; positives by larger {exp,mant}; negatives by smaller {exp,mant}; +0 == -0; on equality keep the earlier value; no NaN/Inf special-casing (bit-order rule applies).
REQ-018 SHALL, when relu_en=1 at the push edge and pooled sign bit = 1, push 16'h0000 instead (so -0 -> +0); relu_en=0 pushes pooled unchanged.
REQ-019 SHALL drive dout = FIFO head entry, dout_valid = FIFO not empty; pop on edge where dout_valid && dout_ready.
REQ-020 SHALL present a pushed value on dout with dout_valid=1 in the cycle after the push edge when the FIFO was empty (latency 1 cycle from 4th sample).
REQ-021 SHALL accept a push when FIFO not full, or when full and a pop occurs on the same edge; occupancy then unchanged.
REQ-022 SHALL, when push is refused (full, no pop), drop the value, set overflow=1 until rst/clear, and still advance phase and group_cnt.
REQ-023 SHALL increment group_cnt on every phase-3 acceptance, dropped or not.
REQ-024 SHALL ignore dout_ready while empty; no pop, no pointer change.
REQ-025 SHALL wrap read/write pointers modulo FIFO_DEPTH; full/empty distinguished by an extra pointer bit or occupancy counter.
REQ-026 SHALL give clear priority over din_valid and dout_ready in the same cycle: phase=0, running max=0, FIFO emptied, overflow=0, group_cnt=0; samples in that cycle discarded.
REQ-027 SHALL keep a partial group (phase 1-3) indefinitely across idle cycles without timeout.

Reset
REQ-028 SHALL, on rst=1 asynchronously, force dout_valid=0, dout=16'h0000, fifo_full=0, overflow=0, group_cnt=0, phase=0, running max=0, pointers=0.
REQ-029 SHALL keep state at reset values while rst=1 and resume on the first rising edge after deassertion; rst mid-group discards the partial group.

Verification
REQ-030 SHALL cover: din 0x3C00,0x4000,0xBC00,0x3800 (1,2,-1,0.5), relu_en=0 -> one cycle later dout=0x4000, dout_valid=1, group_cnt=1.
REQ-031 SHALL cover: din 0xBC00,0xC000,0xB800,0xC200, relu_en=1 -> dout=0x0000; relu_en=0 -> dout=0xB800.
REQ-032 SHALL cover: dout_ready=0, 9 groups with FIFO_DEPTH=8 -> fifo_full=1 after 8th, overflow=1 after 9th, group_cnt=9, drained values = first 8 maxima in order.
REQ-033 SHALL cover: FIFO full, 4th sample edge coincides with dout_ready=1 -> push accepted, overflow stays 0, occupancy stays 8.
REQ-034 SHALL cover: two samples then clear with din_valid=1, then 4 samples 0x3C00 each -> exactly one output 0x3C00, group_cnt=1.
REQ-035 SHALL cover: rst asserted mid-group and with 3 FIFO entries -> dout_valid=0 immediately (asynchronous); next full group yields one correct output.
